// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; OVF exists only when
// PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             OVF;

  modport master (output A, B, Cin, in_valid, out_ready,
                  input  in_ready, S, Cout, out_valid, OVF);
  modport slave  (input  A, B, Cin, in_valid, out_ready,
                  output in_ready, S, Cout, out_valid, OVF);
`else
  modport master (output A, B, Cin, in_valid, out_ready,
                  input  in_ready, S, Cout, out_valid);
  modport slave  (input  A, B, Cin, in_valid, out_ready,
                  output in_ready, S, Cout, out_valid);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder resolved one WIDTH/STAGES-bit slice per clock under valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output OVF.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int SW = (STAGES > 0) ? WIDTH / STAGES : 1;

  logic en;
  logic out_vld;

  if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  assign en           = !out_vld || bus.out_ready;
  assign bus.in_ready = en && !rst;

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_fwd
    localparam int RW = WIDTH - (k + 1) * SW;
    logic [RW-1:0] opa_in;
    logic [RW-1:0] opb_in;
    logic [RW-1:0] opa_r;
    logic [RW-1:0] opb_r;

    if (k == 0) begin : g_src
      assign opa_in = bus.A[WIDTH-1:SW];
      assign opb_in = bus.B[WIDTH-1:SW];
    end else begin : g_src
      assign opa_in = g_fwd[k-1].opa_r[RW+SW-1:SW];
      assign opb_in = g_fwd[k-1].opb_r[RW+SW-1:SW];
    end

    // Upper operand slices wait here until their own stage comes up.
    always_ff @(posedge clk) begin
      if (rst) begin
        opa_r <= '0;
        opb_r <= '0;
      end else if (en) begin
        opa_r <= opa_in;
        opb_r <= opb_in;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]       a_sl;
    logic [SW-1:0]       b_sl;
    logic                c_in;
    logic                v_in;
    logic [SW:0]         slice;
    logic [(k+1)*SW-1:0] sum_nxt;
    logic [(k+1)*SW-1:0] sum_r;
    logic                cy_r;
    logic                vld_r;

    if (k == 0) begin : g_src
      assign a_sl    = bus.A[SW-1:0];
      assign b_sl    = bus.B[SW-1:0];
      assign c_in    = bus.Cin;
      assign v_in    = bus.in_valid;
      assign sum_nxt = slice[SW-1:0];
    end else begin : g_src
      assign a_sl    = g_fwd[k-1].opa_r[SW-1:0];
      assign b_sl    = g_fwd[k-1].opb_r[SW-1:0];
      assign c_in    = g_stage[k-1].cy_r;
      assign v_in    = g_stage[k-1].vld_r;
      assign sum_nxt = {slice[SW-1:0], g_stage[k-1].sum_r};
    end

    assign slice = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_in};

    // Resolve this slice; valid bit, partial sum and carry advance together.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        cy_r  <= 1'b0;
        sum_r <= '0;
      end else if (en) begin
        vld_r <= v_in;
        cy_r  <= slice[SW];
        sum_r <= sum_nxt;
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign out_vld       = vld_r;
      assign bus.out_valid = vld_r;
      assign bus.S         = sum_r;
      assign bus.Cout      = cy_r;
`ifdef PIPELINED_ADDER_OVF_EN
      logic ovf_r;

      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= (slice[SW-1] ^ a_sl[SW-1] ^ b_sl[SW-1]) ^ slice[SW];
        end
      end

      assign bus.OVF = ovf_r;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: a 1-bit/1-stage and a 32-bit/4-stage pipelined_adder side by side.
module tb_pipelined_adder;
  typedef struct {
    logic [32:0] exp;
    logic        ovf;
    int          acc;
    bit          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  sb_t  q1[$];
  sb_t  q32[$];

  pipelined_adder_if #(.WIDTH(1))  bus1 ();
  pipelined_adder_if #(.WIDTH(32)) bus32 ();

  pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the 1-bit adder: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    sb_t e;
    #2;
    if (!rst && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
      n_total++;
      if (q1.size() == 0) begin
        $display("FAIL sb1_extra: got S=%b Cout=%b, required no output", bus1.S, bus1.Cout);
      end else begin
        e = q1.pop_front();
        if ({bus1.Cout, bus1.S} !== e.exp[1:0])
          $display("FAIL sb1_sum: got {Cout,S}=%b required %b", {bus1.Cout, bus1.S}, e.exp[1:0]);
        else
          n_pass++;
        if (e.lat) begin
          n_total++;
          if (cyc - e.acc != 1)
            $display("FAIL sb1_latency: got %0d cycles required 1", cyc - e.acc);
          else
            n_pass++;
        end
      end
    end
  end

  // Scoreboard for the 32-bit adder, including latency and OVF when present.
  always @(negedge clk) begin
    sb_t e;
    #2;
    if (!rst && bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
      n_total++;
      if (q32.size() == 0) begin
        $display("FAIL sb32_extra: got S=%h Cout=%b, required no output", bus32.S, bus32.Cout);
      end else begin
        e = q32.pop_front();
        if ({bus32.Cout, bus32.S} !== e.exp)
          $display("FAIL sb32_sum: got {Cout,S}=%h required %h", {bus32.Cout, bus32.S}, e.exp);
        else
          n_pass++;
        if (e.lat) begin
          n_total++;
          if (cyc - e.acc != 4)
            $display("FAIL sb32_latency: got %0d cycles required 4", cyc - e.acc);
          else
            n_pass++;
        end
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++;
        if (bus32.OVF !== e.ovf)
          $display("FAIL sb32_ovf: got %b required %b (exp sum %h)", bus32.OVF, e.ovf, e.exp);
        else
          n_pass++;
`endif
      end
    end
  end

  task automatic send1(input logic a, input logic b, input logic cin, input bit lat);
    sb_t        e;
    logic [1:0] sum;
    int         guard;
    sum   = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    e.exp = {31'd0, sum};
    e.ovf = 1'b0;
    e.lat = lat;
    bus1.A = a; bus1.B = b; bus1.Cin = cin; bus1.in_valid = 1'b1;
    guard = 0;
    #1;
    while (bus1.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    n_total++;
    if (bus1.in_ready !== 1'b1) begin
      $display("FAIL send1_accept: in_ready=%b after %0d cycles, required 1", bus1.in_ready, guard);
    end else begin
      n_pass++;
      e.acc = cyc;
      q1.push_back(e);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input bit lat);
    sb_t         e;
    logic [32:0] sum;
    int          guard;
    sum   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.exp = sum;
    e.ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    e.lat = lat;
    bus32.A = a; bus32.B = b; bus32.Cin = cin; bus32.in_valid = 1'b1;
    guard = 0;
    #1;
    while (bus32.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    n_total++;
    if (bus32.in_ready !== 1'b1) begin
      $display("FAIL send32_accept: in_ready=%b after %0d cycles, required 1", bus32.in_ready, guard);
    end else begin
      n_pass++;
      e.acc = cyc;
      q32.push_back(e);
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q32.size() != 0) && n < budget) begin
      @(negedge clk); #3; n++;
    end
    n_total++;
    if (q1.size() != 0 || q32.size() != 0)
      $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0/0", q1.size(), q32.size());
    else
      n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (bus32.in_ready !== 1'b0 || bus1.in_ready !== 1'b0)
      $display("FAIL reset_in_ready: got %b/%b required 0/0", bus1.in_ready, bus32.in_ready);
    else n_pass++;
    n_total++;
    if (bus32.out_valid !== 1'b0 || bus32.S !== 32'h0 || bus32.Cout !== 1'b0)
      $display("FAIL reset_out32: got v=%b S=%h C=%b required 0/0/0", bus32.out_valid, bus32.S, bus32.Cout);
    else n_pass++;
    n_total++;
    if (bus1.out_valid !== 1'b0 || bus1.S !== 1'b0 || bus1.Cout !== 1'b0)
      $display("FAIL reset_out1: got v=%b S=%b C=%b required 0/0/0", bus1.out_valid, bus1.S, bus1.Cout);
    else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
    n_total++;
    if (bus32.OVF !== 1'b0) $display("FAIL reset_ovf: got %b required 0", bus32.OVF);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus32.in_ready !== 1'b1 || bus1.in_ready !== 1'b1)
      $display("FAIL release_in_ready: got %b/%b required 1/1", bus1.in_ready, bus32.in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [2:0] v;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      send1(v[2], v[1], v[0], 1'b1);
    end
    wait_drain(20);
  endtask

  task automatic test_carry_ripple();
    bus32.out_ready = 1'b1;
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_total++;
      if (bus32.out_valid !== 1'b0)
        $display("FAIL ripple_early: out_valid=%b at cycle %0d after accept, required 0", bus32.out_valid, i + 1);
      else n_pass++;
      @(negedge clk);
    end
    #2;
    n_total++;
    if (bus32.out_valid !== 1'b1 || bus32.S !== 32'h0000_0000 || bus32.Cout !== 1'b1)
      $display("FAIL ripple_result: got v=%b S=%h C=%b required 1/00000000/1", bus32.out_valid, bus32.S, bus32.Cout);
    else n_pass++;
    @(negedge clk);
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_drain(20);
  endtask

  task automatic test_streaming();
    logic [31:0] v;
    int          start;
    bus32.out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      v = 32'(i);
      send32(v, v << 4, v[0], 1'b1);
    end
    n_total++;
    if (cyc - start != 8)
      $display("FAIL stream_rate: 8 ops took %0d cycles, required 8", cyc - start);
    else n_pass++;
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    logic [31:0] ra[5];
    logic [31:0] rb[5];
    logic [32:0] exp0;
    for (int i = 0; i < 5; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    exp0 = {1'b0, ra[0]} + {1'b0, rb[0]};
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send32(ra[i], rb[i], 1'b0, 1'b0);
    bus32.A = ra[4]; bus32.B = rb[4]; bus32.Cin = 1'b1; bus32.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus32.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b required 0", bus32.in_ready);
      else n_pass++;
      #1;
      n_total++;
      if (bus32.out_valid !== 1'b1 || {bus32.Cout, bus32.S} !== exp0)
        $display("FAIL stall_hold: got v=%b {C,S}=%h required 1/%h", bus32.out_valid, {bus32.Cout, bus32.S}, exp0);
      else n_pass++;
      @(negedge clk);
    end
    bus32.out_ready = 1'b1;
    send32(ra[4], rb[4], 1'b1, 1'b0);
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    bus32.out_ready = 1'b1;
    send32(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    send32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    send32(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
    rst = 1'b1;
    q1.delete();
    q32.delete();
    #1;
    n_total++;
    if (bus32.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b required 0", bus32.in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_total++;
    if (bus32.out_valid !== 1'b0 || bus32.S !== 32'h0 || bus32.Cout !== 1'b0)
      $display("FAIL midrst_clear: got v=%b S=%h C=%b required 0/0/0", bus32.out_valid, bus32.S, bus32.Cout);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      n_total++;
      if (bus32.out_valid !== 1'b0)
        $display("FAIL midrst_stale: out_valid=%b %0d cycles after reset, required 0", bus32.out_valid, i + 1);
      else n_pass++;
    end
    @(negedge clk);
    send32(32'h0000_00FF, 32'h0000_0F01, 1'b0, 1'b1);
    wait_drain(20);
  endtask

`ifdef PIPELINED_ADDER_OVF_EN
  task automatic test_ovf();
    bus32.out_ready = 1'b1;
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    send32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send32(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    wait_drain(20);
  endtask
`endif

  initial begin
    bus1.A = 1'b0; bus1.B = 1'b0; bus1.Cin = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus32.A = 32'h0; bus32.B = 32'h0; bus32.Cin = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    test_reset();
    test_width1();
    test_carry_ripple();
    test_streaming();
    test_backpressure();
    test_reset_mid();
`ifdef PIPELINED_ADDER_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
